// File: rtl/mem_ctrl.sv
// Byte-serial memory controller that arbitrates instruction fetches and LSU accesses onto one byte-wide RAM port.
// Multi-byte accesses are serialised little-endian. Rollback cancels fetches and loads; stores always complete.
module mem_ctrl #(
    parameter int RAM_ADDR_WIDTH = 17
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_rollback,
    input  logic                      in_fetch_ena,
    input  logic [31:0]               in_fetch_addr,
    output logic                      out_fetch_ready,
    output logic [31:0]               out_fetch_data,
    input  logic                      in_ls_ena,
    input  logic                      in_ls_iswrite,
    input  logic [31:0]               in_ls_addr,
    input  logic [2:0]                in_ls_size,
    input  logic [31:0]               in_ls_data,
    output logic                      out_ls_ready,
    output logic [31:0]               out_ls_data,
    output logic [RAM_ADDR_WIDTH-1:0] out_ram_addr,
    output logic                      out_ram_wr,
    output logic [7:0]                out_ram_data,
    input  logic [7:0]                in_ram_data
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  size;
        logic        wr;
    } req_t;

    state_t      state_q;
    req_t        cur_q, fslot_q, lslot_q;
    logic        fpend_q, lpend_q, cur_fetch_q;
    logic [2:0]  cnt_q;
    logic [31:0] asm_q;

    function automatic logic [RAM_ADDR_WIDTH-1:0] ram_addr(input logic [31:0] base, input logic [2:0] c);
        return RAM_ADDR_WIDTH'(base + {29'd0, c});
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] d, input logic [1:0] c);
        logic [31:0] s;
        s = d >> {c, 3'b000};
        return s[7:0];
    endfunction

    logic [2:0]  ls_size_d, cnt_inc;
    logic [1:0]  lane_d;
    req_t        fnew_d, lnew_d, fslot_d, lslot_d, start_d;
    logic        fpend_d, lpend_d, start_fetch_d;
    logic [31:0] asm_d;

    // Slot view as seen at this edge: includes this cycle's pulse and rollback effects.
    always_comb begin
        ls_size_d     = (in_ls_size == 3'd1 || in_ls_size == 3'd2) ? in_ls_size : 3'd4;
        fnew_d        = '{addr: in_fetch_addr, data: 32'd0, size: 3'd4, wr: 1'b0};
        lnew_d        = '{addr: in_ls_addr, data: in_ls_data, size: ls_size_d, wr: in_ls_iswrite};
        fpend_d       = (fpend_q | in_fetch_ena) & ~in_rollback;
        fslot_d       = fpend_q ? fslot_q : fnew_d;
        lpend_d       = (lpend_q & ~(in_rollback & ~lslot_q.wr))
                      | (in_ls_ena & ~(in_rollback & ~in_ls_iswrite));
        lslot_d       = lpend_q ? lslot_q : lnew_d;
        start_fetch_d = ~lpend_d;
        start_d       = lpend_d ? lslot_d : fslot_d;
        cnt_inc       = cnt_q + 3'd1;
        lane_d        = cnt_q[1:0] - 2'd1;
        asm_d         = asm_q;
        // The RAM byte seen now belongs to the address issued one cycle earlier.
        if (cnt_q != 3'd0)
            asm_d[{lane_d, 3'b000} +: 8] = in_ram_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            cur_q           <= '0;
            fslot_q         <= '0;
            lslot_q         <= '0;
            fpend_q         <= 1'b0;
            lpend_q         <= 1'b0;
            cur_fetch_q     <= 1'b0;
            cnt_q           <= 3'd0;
            asm_q           <= 32'd0;
            out_fetch_ready <= 1'b0;
            out_fetch_data  <= 32'd0;
            out_ls_ready    <= 1'b0;
            out_ls_data     <= 32'd0;
            out_ram_addr    <= '0;
            out_ram_wr      <= 1'b0;
            out_ram_data    <= 8'd0;
        end else begin
            out_fetch_ready <= 1'b0;
            out_ls_ready    <= 1'b0;
            fpend_q         <= fpend_d;
            lpend_q         <= lpend_d;
            fslot_q         <= fslot_d;
            lslot_q         <= lslot_d;
            case (state_q)
                IDLE: begin
                    if (lpend_d || fpend_d) begin
                        cur_q        <= start_d;
                        cur_fetch_q  <= start_fetch_d;
                        cnt_q        <= 3'd0;
                        asm_q        <= 32'd0;
                        out_ram_addr <= ram_addr(start_d.addr, 3'd0);
                        out_ram_wr   <= start_d.wr;
                        out_ram_data <= start_d.wr ? start_d.data[7:0] : 8'd0;
                        state_q      <= start_d.wr ? WRITE : READ;
                        if (start_fetch_d) fpend_q <= 1'b0;
                        else               lpend_q <= 1'b0;
                    end
                end
                READ: begin
                    if (in_rollback) begin
                        state_q      <= IDLE;
                        cnt_q        <= 3'd0;
                        out_ram_addr <= '0;
                    end else if (cnt_q == cur_q.size) begin
                        state_q      <= IDLE;
                        cnt_q        <= 3'd0;
                        out_ram_addr <= '0;
                        if (cur_fetch_q) begin
                            out_fetch_ready <= 1'b1;
                            out_fetch_data  <= asm_d;
                        end else begin
                            out_ls_ready <= 1'b1;
                            out_ls_data  <= asm_d;
                        end
                    end else begin
                        asm_q        <= asm_d;
                        cnt_q        <= cnt_inc;
                        out_ram_addr <= ram_addr(cur_q.addr, cnt_inc);
                    end
                end
                WRITE: begin
                    if (cnt_inc == cur_q.size) begin
                        state_q      <= IDLE;
                        cnt_q        <= 3'd0;
                        out_ram_addr <= '0;
                        out_ram_wr   <= 1'b0;
                        out_ram_data <= 8'd0;
                        out_ls_ready <= 1'b1;
                    end else begin
                        cnt_q        <= cnt_inc;
                        out_ram_addr <= ram_addr(cur_q.addr, cnt_inc);
                        out_ram_data <= lane_byte(cur_q.data, cnt_inc[1:0]);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a behavioural synchronous byte RAM plus per-cycle logs checked against hand-computed values.
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_rollback = 1'b0;
    logic        in_fetch_ena = 1'b0;
    logic [31:0] in_fetch_addr = 32'd0;
    logic        out_fetch_ready;
    logic [31:0] out_fetch_data;
    logic        in_ls_ena = 1'b0;
    logic        in_ls_iswrite = 1'b0;
    logic [31:0] in_ls_addr = 32'd0;
    logic [2:0]  in_ls_size = 3'd0;
    logic [31:0] in_ls_data = 32'd0;
    logic        out_ls_ready;
    logic [31:0] out_ls_data;
    logic [16:0] out_ram_addr;
    logic        out_ram_wr;
    logic [7:0]  out_ram_data;
    logic [7:0]  in_ram_data;

    mem_ctrl #(.RAM_ADDR_WIDTH(17)) dut (
        .clk(clk), .rst(rst), .in_rollback(in_rollback),
        .in_fetch_ena(in_fetch_ena), .in_fetch_addr(in_fetch_addr),
        .out_fetch_ready(out_fetch_ready), .out_fetch_data(out_fetch_data),
        .in_ls_ena(in_ls_ena), .in_ls_iswrite(in_ls_iswrite), .in_ls_addr(in_ls_addr),
        .in_ls_size(in_ls_size), .in_ls_data(in_ls_data),
        .out_ls_ready(out_ls_ready), .out_ls_data(out_ls_data),
        .out_ram_addr(out_ram_addr), .out_ram_wr(out_ram_wr),
        .out_ram_data(out_ram_data), .in_ram_data(in_ram_data)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:131071];
    always @(posedge clk) begin
        if (out_ram_wr) mem[out_ram_addr] <= out_ram_data;
        in_ram_data <= mem[out_ram_addr];
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] a_log  [0:15];
    logic        w_log  [0:15];
    logic [7:0]  d_log  [0:15];
    logic        fr_log [0:15];
    logic        lr_log [0:15];
    logic [31:0] fd_log [0:15];
    logic [31:0] ld_log [0:15];

    // Steps from cycle 'from' to cycle 'to', dropping request pulses after their sampling edge.
    task automatic run(input int from, input int to);
        for (int c = from + 1; c <= to; c++) begin
            @(posedge clk); #1;
            in_fetch_ena = 1'b0;
            in_ls_ena    = 1'b0;
            in_rollback  = 1'b0;
            a_log[c]  = 32'(out_ram_addr);
            w_log[c]  = out_ram_wr;
            d_log[c]  = out_ram_data;
            fr_log[c] = out_fetch_ready;
            lr_log[c] = out_ls_ready;
            fd_log[c] = out_fetch_data;
            ld_log[c] = out_ls_data;
        end
    endtask

    task automatic chk_rdy(input string tag, input int n, input int fcyc, input int lcyc);
        for (int c = 1; c <= n; c++) begin
            chk($sformatf("%s frdy@%0d", tag, c), 32'(fr_log[c]), 32'(c == fcyc));
            chk($sformatf("%s lrdy@%0d", tag, c), 32'(lr_log[c]), 32'(c == lcyc));
        end
    endtask

    task automatic fetch(input logic [31:0] a);
        in_fetch_ena  = 1'b1;
        in_fetch_addr = a;
    endtask

    task automatic ls(input logic wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        in_ls_ena     = 1'b1;
        in_ls_iswrite = wr;
        in_ls_addr    = a;
        in_ls_size    = sz;
        in_ls_data    = d;
    endtask

    initial begin
        for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
        mem[17'h100] = 8'h13; mem[17'h101] = 8'h05; mem[17'h102] = 8'h10; mem[17'h103] = 8'h00;
        mem[17'h020] = 8'hAB; mem[17'h021] = 8'hCD;
        mem[17'h200] = 8'h01; mem[17'h201] = 8'h02; mem[17'h202] = 8'h03; mem[17'h203] = 8'h04;
        mem[17'h1FFFE] = 8'h11; mem[17'h1FFFF] = 8'h22; mem[17'h0] = 8'h33; mem[17'h1] = 8'h44;

        @(posedge clk); #1;
        chk("rst fetch_ready", 32'(out_fetch_ready), 0);
        chk("rst ls_ready", 32'(out_ls_ready), 0);
        chk("rst fetch_data", out_fetch_data, 0);
        chk("rst ls_data", out_ls_data, 0);
        chk("rst ram_addr", 32'(out_ram_addr), 0);
        chk("rst ram_wr", 32'(out_ram_wr), 0);
        chk("rst ram_data", 32'(out_ram_data), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Fetch from idle
        fetch(32'h100);
        run(0, 7);
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("f1 addr@%0d", c), a_log[c], 32'h100 + 32'(c - 1));
            chk($sformatf("f1 wr@%0d", c), 32'(w_log[c]), 0);
        end
        chk_rdy("f1", 7, 6, 0);
        chk("f1 data", fd_log[6], 32'h00100513);

        // Simultaneous fetch and load: load first
        fetch(32'h0);
        ls(1'b0, 32'h20, 3'd2, 32'd0);
        run(0, 11);
        chk("sim laddr1", a_log[1], 32'h20);
        chk("sim laddr2", a_log[2], 32'h21);
        for (int c = 5; c <= 8; c++) chk($sformatf("sim faddr@%0d", c), a_log[c], 32'(c - 5));
        chk_rdy("sim", 11, 10, 4);
        chk("sim ldata", ld_log[4], 32'h0000CDAB);
        chk("sim fdata", fd_log[10], 32'h00004433);

        // Store word, then load it back
        ls(1'b1, 32'h40, 3'd4, 32'hDEADBEEF);
        run(0, 6);
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("st wr@%0d", c), 32'(w_log[c]), 1);
            chk($sformatf("st addr@%0d", c), a_log[c], 32'h40 + 32'(c - 1));
        end
        chk("st wr@5", 32'(w_log[5]), 0);
        chk("st b0", 32'(d_log[1]), 32'hEF);
        chk("st b1", 32'(d_log[2]), 32'hBE);
        chk("st b2", 32'(d_log[3]), 32'hAD);
        chk("st b3", 32'(d_log[4]), 32'hDE);
        chk_rdy("st", 6, 0, 5);
        ls(1'b0, 32'h40, 3'd4, 32'd0);
        run(0, 7);
        chk_rdy("ldb", 7, 0, 6);
        chk("ldb data", ld_log[6], 32'hDEADBEEF);

        // Rollback mid-fetch, then a fresh fetch
        fetch(32'h100);
        run(0, 2);
        in_rollback = 1'b1;
        run(2, 4);
        fetch(32'h200);
        run(4, 11);
        chk("rb addr1", a_log[1], 32'h100);
        chk("rb addr2", a_log[2], 32'h101);
        chk("rb addr3", a_log[3], 0);
        chk("rb addr4", a_log[4], 0);
        chk_rdy("rb", 11, 10, 0);
        chk("rb fdata", fd_log[10], 32'h04030201);

        // Rollback during a store while a load is pending
        ls(1'b1, 32'h300, 3'd2, 32'h1234A55A);
        run(0, 1);
        ls(1'b0, 32'h300, 3'd2, 32'd0);
        run(1, 2);
        in_rollback = 1'b1;
        run(2, 9);
        chk("rbst wr1", 32'(w_log[1]), 1);
        chk("rbst wr2", 32'(w_log[2]), 1);
        chk("rbst addr2", a_log[2], 32'h301);
        chk("rbst b1", 32'(d_log[2]), 32'hA5);
        for (int c = 4; c <= 9; c++) chk($sformatf("rbst idle@%0d", c), a_log[c], 0);
        chk_rdy("rbst", 9, 0, 3);
        ls(1'b0, 32'h300, 3'd2, 32'd0);
        run(0, 5);
        chk("rbst ld", ld_log[4], 32'h0000A55A);

        // Address wrap at top of RAM
        ls(1'b0, 32'h0001FFFE, 3'd4, 32'd0);
        run(0, 7);
        chk("wrap a1", a_log[1], 32'h1FFFE);
        chk("wrap a2", a_log[2], 32'h1FFFF);
        chk("wrap a3", a_log[3], 32'h0);
        chk("wrap a4", a_log[4], 32'h1);
        chk_rdy("wrap", 7, 0, 6);
        chk("wrap data", ld_log[6], 32'h44332211);

        // Byte load zero-extends; odd size code behaves as a word
        ls(1'b0, 32'h101, 3'd1, 32'd0);
        run(0, 4);
        chk_rdy("byte", 4, 0, 3);
        chk("byte data", ld_log[3], 32'h00000005);
        ls(1'b0, 32'h100, 3'd3, 32'd0);
        run(0, 7);
        chk_rdy("sz3", 7, 0, 6);
        chk("sz3 data", ld_log[6], 32'h00100513);
        chk("fdata held", fd_log[7], 32'h04030201);

        // Asynchronous reset mid-fetch
        fetch(32'h100);
        run(0, 2);
        rst = 1'b0;
        #1;
        chk("arst addr", 32'(out_ram_addr), 0);
        chk("arst fdata", out_fetch_data, 0);
        chk("arst ldata", out_ls_data, 0);
        rst = 1'b1;
        run(2, 9);
        for (int c = 3; c <= 9; c++) begin
            chk($sformatf("arst frdy@%0d", c), 32'(fr_log[c]), 0);
            chk($sformatf("arst addr@%0d", c), a_log[c], 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
